cascade_stage_ctrl: RTL and testbench
=====================================

Name: cascade_stage_ctrl

Overview:
Sequences the per-feature evaluation datapath for one detection window through all cascade stages. Issues feature indices stage by stage and sums the returned leaf values per stage. Compares each stage sum against the stage threshold and either advances to the next stage, rejects early, or reports a detection. Sits between the window scheduler (upstream) and the feature-evaluation datapath plus stage ROM (downstream).

Parameters:
FEATURE_NUM, 2913, total features across all stages
STAGE_NUM, 25, number of cascade stages
W_LEAF, 14, signed leaf value width
W_ACC, 22, signed stage accumulator and threshold width
W_ADDR_FEAT, $clog2(FEATURE_NUM), feature index width (localparam)
W_STAGE, $clog2(STAGE_NUM), stage index width (localparam)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
win_valid  in  1  start request for a new window
win_ready  out  1  high only in IDLE
stage_rd  out  1  stage ROM read strobe
stage_addr  out  W_STAGE  stage ROM address
stage_threshold  in  W_ACC  signed stage threshold, valid the cycle after stage_rd
stage_last_feat  in  W_ADDR_FEAT  last feature index of the stage, valid the cycle after stage_rd
feat_valid  out  1  feature request valid
feat_ready  in  1  datapath accepts request
feat_addr  out  W_ADDR_FEAT  feature index
leaf_valid  in  1  leaf result valid
leaf_ready  out  1  high in RUN, otherwise 0
leaf_data  in  W_LEAF  signed leaf value
leaf_eot  in  1  datapath end-of-stage marker, qualified by leaf_valid
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_detect  out  1  1 = passed all stages
res_stage  out  W_STAGE  rejecting stage (STAGE_NUM-1 on detect)
err_eot  out  1  sticky: leaf_eot mismatched the stage boundary

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, stage=0, feat_ptr=0, acc=0, issued/received counters=0, res_valid=0, res_detect=0, res_stage=0, feat_valid=0, stage_rd=0, err_eot=0. Reset mid-window abandons the window; outstanding leaves after reset are ignored (leaf_ready=0 in IDLE).
- IDLE: win_ready=1. Handshake win_valid&win_ready -> LOAD; stage=0, feat_ptr=0, acc=0.
- LOAD (1 cycle): stage_rd=1, stage_addr=stage -> SWAIT.
- SWAIT (1 cycle): capture stage_threshold, stage_last_feat into registers -> RUN.
- RUN: feat_valid=1 while feat_ptr<=last_reg; feat_addr=feat_ptr; feat_ptr increments on each feat_valid&feat_ready. Up to one request per cycle; no request past last_reg. leaf_ready=1; each leaf_valid adds sign-extended leaf_data to acc, saturating at the W_ACC signed max/min (no wrap). Issue and accumulate may occur in the same cycle.
- Stage end: the leaf whose received count equals the stage feature count (last_reg - first + 1). The acc compare uses the sum including that leaf, evaluated next cycle in DECIDE. leaf_eot must be 1 exactly on that leaf; if asserted on any other leaf, or absent on it, set err_eot (cleared only by reset). Flow is unchanged by the error.
- DECIDE (1 cycle): signed compare acc >= thr_reg.
  - Pass with stage<STAGE_NUM-1: stage++, acc=0 -> LOAD; feat_ptr continues from last_reg+1.
  - Pass with stage==STAGE_NUM-1: res_detect=1, res_stage=stage -> RESULT.
  - Fail: res_detect=0, res_stage=stage -> RESULT (early reject, no further features issued).
- RESULT: res_valid=1, outputs stable until res_valid&res_ready -> IDLE (res_valid deasserts next cycle). Backpressure has no depth limit.
- Latency: win handshake at cycle 0 -> stage_rd at cycle 1 -> first feat_valid at cycle 3. Last leaf of the final stage at cycle t -> DECIDE at t+1 -> res_valid at t+2.
- Equality acc==threshold passes. A stage with a single feature (last==first) is legal.

Test Plan:
- Reset: hold rst=0 for 3 cycles with win_valid=1 -> win_ready=1 after release, all outputs at reset values, no feat_valid.
- Full detect, STAGE_NUM=3, last_feat 2/5/9, thresholds 10/10/10, each leaf=+4, feat_ready=1 -> feat_addr 0..9 in order, res_detect=1, res_stage=2.
- Early reject: same setup, stage 1 leaves -1 -> stage 1 sum -3 < 10 -> res_detect=0, res_stage=1, no feat_addr>5 issued.
- Boundary equality and saturation: stage 0 sum exactly 10 -> pass. Leaves +8191 with W_ACC=14 -> acc saturates at 8191, no wrap.
- Backpressure: random feat_ready and leaf_valid gaps, res_ready low 5 cycles -> identical results, res outputs held stable, exactly one feat request per index.
- EOT mismatch: assert leaf_eot on feature 1 -> err_eot=1 and sticky, result unaffected. Reset mid-RUN -> IDLE, next window runs correctly.

Source files
------------

// File: rtl/cascade_stage_ctrl.sv
// Cascade stage sequencer: walks one detection window through every stage,
// issuing feature requests and summing the returned leaves against each stage threshold.
module cascade_stage_ctrl #(
    parameter  int FEATURE_NUM = 2913,
    parameter  int STAGE_NUM   = 25,
    parameter  int W_LEAF      = 14,
    parameter  int W_ACC       = 22,
    localparam int W_ADDR_FEAT = $clog2(FEATURE_NUM),
    localparam int W_STAGE     = $clog2(STAGE_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       win_valid,
    output logic                       win_ready,
    output logic                       stage_rd,
    output logic [W_STAGE-1:0]         stage_addr,
    input  logic signed [W_ACC-1:0]    stage_threshold,
    input  logic [W_ADDR_FEAT-1:0]     stage_last_feat,
    output logic                       feat_valid,
    input  logic                       feat_ready,
    output logic [W_ADDR_FEAT-1:0]     feat_addr,
    input  logic                       leaf_valid,
    output logic                       leaf_ready,
    input  logic signed [W_LEAF-1:0]   leaf_data,
    input  logic                       leaf_eot,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_detect,
    output logic [W_STAGE-1:0]         res_stage,
    output logic                       err_eot
);

    typedef enum logic [2:0] {IDLE, LOAD, SWAIT, RUN, DECIDE, RESULT} state_t;

    localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};
    localparam logic [W_STAGE-1:0]      LAST_STAGE = W_STAGE'(STAGE_NUM - 1);

    state_t state, state_nxt;

    logic [W_STAGE-1:0]      stage;
    // One extra bit so the pointer can sit past last_reg without wrapping onto index 0.
    logic [W_ADDR_FEAT:0]    feat_ptr;
    logic [W_ADDR_FEAT:0]    first_reg;
    logic [W_ADDR_FEAT:0]    last_reg;
    logic [W_ADDR_FEAT:0]    recv_cnt;
    logic [W_ADDR_FEAT:0]    stage_cnt;
    logic signed [W_ACC-1:0] thr_reg;
    logic signed [W_ACC-1:0] acc;
    logic signed [W_ACC-1:0] acc_sat;
    logic signed [W_ACC:0]   sum_wide;
    logic [W_ACC:0]          leaf_ext;
    logic                    leaf_fire;
    logic                    feat_fire;
    logic                    stage_end;
    logic                    pass;

    assign stage_cnt = last_reg - first_reg + 1'b1;
    assign leaf_fire = (state == RUN) && leaf_valid;
    assign feat_fire = feat_valid && feat_ready;
    assign stage_end = leaf_fire && ((recv_cnt + 1'b1) == stage_cnt);
    assign pass      = (acc >= thr_reg);

    // Sum in one extra bit and clamp when the sign of the result disagrees with the carry.
    always_comb begin
        leaf_ext = {{(W_ACC + 1 - W_LEAF){leaf_data[W_LEAF-1]}}, leaf_data};
        sum_wide = {acc[W_ACC-1], acc} + leaf_ext;
        if (sum_wide[W_ACC] != sum_wide[W_ACC-1])
            acc_sat = sum_wide[W_ACC] ? ACC_MIN : ACC_MAX;
        else
            acc_sat = sum_wide[W_ACC-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = LOAD;
            LOAD:    state_nxt = SWAIT;
            SWAIT:   state_nxt = RUN;
            RUN:     if (stage_end) state_nxt = DECIDE;
            DECIDE:  state_nxt = (pass && stage != LAST_STAGE) ? LOAD : RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        win_ready  = (state == IDLE);
        stage_rd   = (state == LOAD);
        feat_valid = (state == RUN) && (feat_ptr <= last_reg);
        leaf_ready = (state == RUN);
        res_valid  = (state == RESULT);
    end

    assign stage_addr = stage;
    assign feat_addr  = feat_ptr[W_ADDR_FEAT-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage      <= '0;
            feat_ptr   <= '0;
            first_reg  <= '0;
            last_reg   <= '0;
            recv_cnt   <= '0;
            thr_reg    <= '0;
            acc        <= '0;
            res_detect <= 1'b0;
            res_stage  <= '0;
            err_eot    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        stage    <= '0;
                        feat_ptr <= '0;
                        acc      <= '0;
                    end
                end
                SWAIT: begin
                    thr_reg   <= stage_threshold;
                    last_reg  <= {1'b0, stage_last_feat};
                    first_reg <= feat_ptr;
                    recv_cnt  <= '0;
                end
                RUN: begin
                    if (feat_fire)
                        feat_ptr <= feat_ptr + 1'b1;
                    if (leaf_fire) begin
                        acc      <= acc_sat;
                        recv_cnt <= recv_cnt + 1'b1;
                        if (leaf_eot != stage_end)
                            err_eot <= 1'b1;
                    end
                end
                DECIDE: begin
                    if (pass && stage != LAST_STAGE) begin
                        stage    <= stage + 1'b1;
                        acc      <= '0;
                        feat_ptr <= last_reg + 1'b1;
                    end else begin
                        res_detect <= pass;
                        res_stage  <= stage;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cascade_stage_ctrl.sv
// Scoreboard bench for cascade_stage_ctrl: a stage ROM model, a leaf-returning
// datapath model and a result monitor checked against hand-computed expectations.
module tb_cascade_stage_ctrl;

    localparam int FEATURE_NUM = 16;
    localparam int STAGE_NUM   = 3;
    localparam int W_LEAF      = 14;
    localparam int W_ACC       = 14;
    localparam int W_AF        = $clog2(FEATURE_NUM);
    localparam int W_ST        = $clog2(STAGE_NUM);

    typedef struct {
        bit detect;
        int stage;
        int nfeat;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic                     win_valid;
    logic                     win_ready;
    logic                     stage_rd;
    logic [W_ST-1:0]          stage_addr;
    logic signed [W_ACC-1:0]  stage_threshold;
    logic [W_AF-1:0]          stage_last_feat;
    logic                     feat_valid;
    logic                     feat_ready;
    logic [W_AF-1:0]          feat_addr;
    logic                     leaf_valid;
    logic                     leaf_ready;
    logic signed [W_LEAF-1:0] leaf_data;
    logic                     leaf_eot;
    logic                     res_valid;
    logic                     res_ready;
    logic                     res_detect;
    logic [W_ST-1:0]          res_stage;
    logic                     err_eot;

    int   n_checks = 0;
    int   n_errors = 0;
    int   thr_tab[STAGE_NUM];
    int   last_tab[STAGE_NUM];
    int   leaf_tab[FEATURE_NUM];
    int   pend[$];
    exp_t exp_q[$];
    int   feat_cnt = 0;
    int   results_seen = 0;
    int   bad_eot_addr = -1;
    int   hold_cnt = 0;
    bit   gap_mode = 0;

    cascade_stage_ctrl #(
        .FEATURE_NUM(FEATURE_NUM),
        .STAGE_NUM  (STAGE_NUM),
        .W_LEAF     (W_LEAF),
        .W_ACC      (W_ACC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .win_valid      (win_valid),
        .win_ready      (win_ready),
        .stage_rd       (stage_rd),
        .stage_addr     (stage_addr),
        .stage_threshold(stage_threshold),
        .stage_last_feat(stage_last_feat),
        .feat_valid     (feat_valid),
        .feat_ready     (feat_ready),
        .feat_addr      (feat_addr),
        .leaf_valid     (leaf_valid),
        .leaf_ready     (leaf_ready),
        .leaf_data      (leaf_data),
        .leaf_eot       (leaf_eot),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_detect     (res_detect),
        .res_stage      (res_stage),
        .err_eot        (err_eot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_eot(input int a);
        bit r;
        r = (a == bad_eot_addr);
        for (int s = 0; s < STAGE_NUM; s++)
            if (a == last_tab[s]) r = 1'b1;
        return r;
    endfunction

    // Stage ROM: one-cycle read latency.
    always @(posedge clk) begin
        if (stage_rd) begin
            stage_threshold <= W_ACC'(thr_tab[stage_addr]);
            stage_last_feat <= W_AF'(last_tab[stage_addr]);
        end
    end

    // Datapath model: accepts feature requests and returns one leaf per request, in order.
    initial begin
        feat_ready = 1'b0;
        leaf_valid = 1'b0;
        leaf_data  = '0;
        leaf_eot   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend.delete();
                feat_ready = 1'b0;
                leaf_valid = 1'b0;
                leaf_eot   = 1'b0;
            end else begin
                feat_ready = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pend.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
                    leaf_valid = 1'b1;
                    leaf_data  = W_LEAF'(leaf_tab[pend[0]]);
                    leaf_eot   = is_eot(pend[0]);
                end else begin
                    leaf_valid = 1'b0;
                    leaf_eot   = 1'b0;
                end
                if (leaf_valid && leaf_ready)
                    pend.delete(0);
                if (feat_valid && feat_ready) begin
                    checkOutput("feat_addr", 32'(feat_addr), 32'(feat_cnt));
                    pend.push_back(int'(feat_addr));
                    feat_cnt++;
                end
            end
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (res_valid && hold_cnt > 0) begin
                res_ready = 1'b0;
                hold_cnt--;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // Result monitor: pops one expectation per result and re-checks it every held cycle.
    initial begin
        bit   holding;
        exp_t cur;
        holding = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                holding = 0;
            end else if (res_valid) begin
                if (!holding) begin
                    holding = 1;
                    checkOutput("result_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        checkOutput("res_detect", 32'(res_detect), 32'(cur.detect));
                        checkOutput("res_stage", 32'(res_stage), 32'(cur.stage));
                        checkOutput("feat_count", 32'(feat_cnt), 32'(cur.nfeat));
                    end
                    feat_cnt = 0;
                    results_seen++;
                end else begin
                    checkOutput("res_detect_held", 32'(res_detect), 32'(cur.detect));
                    checkOutput("res_stage_held", 32'(res_stage), 32'(cur.stage));
                end
            end else begin
                holding = 0;
            end
        end
    end

    task automatic applyStimulus(input bit det, input int stg, input int nf, input bit wait_res);
        int n;
        int target;
        exp_t e;
        if (wait_res) begin
            e.detect = det;
            e.stage  = stg;
            e.nfeat  = nf;
            exp_q.push_back(e);
        end
        target = results_seen + 1;
        win_valid = 1'b1;
        n = 0;
        while (!win_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("win_handshake", 32'(win_ready), 32'd1);
        @(negedge clk);
        win_valid = 1'b0;
        checkOutput("stage_rd_cycle1", 32'(stage_rd), 32'd1);
        checkOutput("stage_addr_cycle1", 32'(stage_addr), 32'd0);
        @(negedge clk);
        checkOutput("feat_valid_cycle2", 32'(feat_valid), 32'd0);
        @(negedge clk);
        checkOutput("feat_valid_cycle3", 32'(feat_valid), 32'd1);
        if (wait_res) begin
            n = 0;
            while (results_seen < target && n < 1000) begin
                @(negedge clk);
                n++;
            end
            checkOutput("result_timeout", 32'(results_seen >= target), 32'd1);
            n = 0;
            while (res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic setTables(input int l0, input int l1, input int l2,
                             input int t0, input int t1, input int t2, input int leaf);
        last_tab[0] = l0; last_tab[1] = l1; last_tab[2] = l2;
        thr_tab[0]  = t0; thr_tab[1]  = t1; thr_tab[2]  = t2;
        for (int i = 0; i < FEATURE_NUM; i++)
            leaf_tab[i] = leaf;
    endtask

    initial begin
        rst       = 1'b0;
        win_valid = 1'b1;
        setTables(2, 5, 9, 10, 10, 10, 4);

        repeat (3) @(negedge clk);
        checkOutput("rst_win_ready", 32'(win_ready), 32'd1);
        checkOutput("rst_feat_valid", 32'(feat_valid), 32'd0);
        checkOutput("rst_stage_rd", 32'(stage_rd), 32'd0);
        checkOutput("rst_leaf_ready", 32'(leaf_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_detect", 32'(res_detect), 32'd0);
        checkOutput("rst_res_stage", 32'(res_stage), 32'd0);
        checkOutput("rst_err_eot", 32'(err_eot), 32'd0);
        rst       = 1'b1;
        win_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_win_ready", 32'(win_ready), 32'd1);
        checkOutput("post_rst_feat_valid", 32'(feat_valid), 32'd0);

        $display("[TB] full detect, leaves +4");
        applyStimulus(1'b1, 2, 10, 1'b1);

        $display("[TB] early reject in stage 1");
        for (int i = 3; i <= 5; i++) leaf_tab[i] = -1;
        applyStimulus(1'b0, 1, 6, 1'b1);

        $display("[TB] threshold equality");
        setTables(2, 5, 9, 10, 10, 10, 4);
        leaf_tab[0] = 3; leaf_tab[1] = 3; leaf_tab[2] = 4;
        applyStimulus(1'b1, 2, 10, 1'b1);
        leaf_tab[2] = 3;
        applyStimulus(1'b0, 0, 3, 1'b1);

        $display("[TB] saturation");
        setTables(2, 5, 9, 8191, -8192, 8190, 8191);
        for (int i = 3; i <= 5; i++) leaf_tab[i] = -8192;
        leaf_tab[9] = -1;
        applyStimulus(1'b1, 2, 10, 1'b1);

        $display("[TB] single-feature stages");
        setTables(0, 1, 9, 4, 4, 10, 4);
        applyStimulus(1'b1, 2, 10, 1'b1);

        $display("[TB] backpressure");
        setTables(2, 5, 9, 10, 10, 10, 4);
        gap_mode = 1;
        hold_cnt = 5;
        applyStimulus(1'b1, 2, 10, 1'b1);
        for (int i = 3; i <= 5; i++) leaf_tab[i] = -1;
        hold_cnt = 5;
        applyStimulus(1'b0, 1, 6, 1'b1);
        gap_mode = 0;

        $display("[TB] eot mismatch");
        setTables(2, 5, 9, 10, 10, 10, 4);
        checkOutput("err_eot_clean", 32'(err_eot), 32'd0);
        bad_eot_addr = 1;
        applyStimulus(1'b1, 2, 10, 1'b1);
        checkOutput("err_eot_set", 32'(err_eot), 32'd1);
        bad_eot_addr = -1;
        applyStimulus(1'b1, 2, 10, 1'b1);
        checkOutput("err_eot_sticky", 32'(err_eot), 32'd1);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 2, 10, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("midrst_win_ready", 32'(win_ready), 32'd1);
        checkOutput("midrst_feat_valid", 32'(feat_valid), 32'd0);
        checkOutput("midrst_leaf_ready", 32'(leaf_ready), 32'd0);
        checkOutput("midrst_err_eot", 32'(err_eot), 32'd0);
        feat_cnt = 0;
        @(negedge clk);
        applyStimulus(1'b1, 2, 10, 1'b1);
        checkOutput("err_eot_after_rst", 32'(err_eot), 32'd0);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
